// File: rtl/mvm_input_sequencer.sv
// -----------------------------------------------------------------------------
// mvm_input_sequencer
//
// Upstream feeder for a K x K matrix-vector multiplier (MVM). Operands from a
// valid/ready producer are buffered in an internal FIFO. A command replays them
// to the MVM as one frame. A reload frame carries K*K matrix words in row-major
// order followed by K vector words. A vector-only frame carries just the K
// vector words. Each burst is preceded by a one-cycle header pulse, and the
// frame ends with a one-cycle start pulse. The next command is held off until
// the MVM reports done. A frame launches only once every word it needs is
// already buffered, so the MVM always sees gap-free, one-word-per-cycle bursts.
//
// Ports
//   clk               in   1   clock, rising edge
//   reset             in   1   synchronous, active-high
//   s_valid           in   1   producer word valid
//   s_ready           out  1   FIFO has room (count < DEPTH)
//   s_data            in   B   operand word
//   cmd_valid         in   1   request one frame
//   cmd_reload        in   1   1: matrix + vector frame, 0: vector only
//   cmd_ready         out  1   sequencer idle; command accepted this cycle
//   mvm_start_matrix  out  1   pulse preceding the matrix burst
//   mvm_start_vector  out  1   pulse preceding the vector burst
//   mvm_start         out  1   pulse launching the compute
//   mvm_data          out  B   burst word to the MVM (0 outside bursts)
//   mvm_done          in   1   MVM results ready; ends the frame
//   busy              out  1   frame in progress
//   frame_count       out  16  frames completed since reset (wraps)
// -----------------------------------------------------------------------------
module mvm_input_sequencer #(
  parameter int K     = 4,
  parameter int B     = 8,
  parameter int DEPTH = K*K + K
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [B-1:0] s_data,
  input  logic         cmd_valid,
  input  logic         cmd_reload,
  output logic         cmd_ready,
  output logic         mvm_start_matrix,
  output logic         mvm_start_vector,
  output logic         mvm_start,
  output logic [B-1:0] mvm_data,
  input  logic         mvm_done,
  output logic         busy,
  output logic [15:0]  frame_count
);

  localparam int MAT_WORDS  = K*K;
  localparam int FULL_WORDS = K*K + K;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (MAT_WORDS > 1) ? $clog2(MAT_WORDS) : 1;

  localparam logic [IW-1:0] MAT_LAST = IW'(MAT_WORDS - 1);
  localparam logic [IW-1:0] VEC_LAST = IW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_MHDR,
    S_MLOAD,
    S_VHDR,
    S_VLOAD,
    S_GO,
    S_WAIT_DONE
  } state_t;

  state_t        state;
  logic          reload_q;
  logic          matrix_loaded;
  logic [IW-1:0] idx;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [B-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_en, pop_req, pop_en;
  logic [B-1:0]  head;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign s_ready = (count < CW'(DEPTH));
  assign push_en = s_valid && s_ready;
  assign head    = mem[rd_ptr];

  // Pop on every edge that loads a burst word into mvm_data: the header cycle
  // fetches word 0, and each burst cycle except the last fetches the next one.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves pop_req
    // unassigned, which would infer a latch.
    pop_req = 1'b0;
    case (state)
      S_MHDR:  pop_req = 1'b1;
      S_MLOAD: pop_req = (idx != MAT_LAST);
      S_VHDR:  pop_req = 1'b1;
      S_VLOAD: pop_req = (idx != VEC_LAST);
      default: pop_req = 1'b0;
    endcase
  end

  assign pop_en = pop_req && (count != '0);

  // NOTE: the storage array has no reset. Emptiness is tracked by the pointers
  // and count alone, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= s_data;
  end

  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples its pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= ptr_next(wr_ptr);
      if (pop_en)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  logic [CW-1:0] words_needed;
  assign words_needed = reload_q ? CW'(FULL_WORDS) : CW'(K);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      reload_q         <= 1'b0;
      matrix_loaded    <= 1'b0;
      idx              <= '0;
      mvm_start_matrix <= 1'b0;
      mvm_start_vector <= 1'b0;
      mvm_start        <= 1'b0;
      mvm_data         <= '0;
      frame_count      <= '0;
    end else begin
      // Pulses last one cycle, and data is zero unless a burst word is loaded.
      mvm_start_matrix <= 1'b0;
      mvm_start_vector <= 1'b0;
      mvm_start        <= 1'b0;
      mvm_data         <= '0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // A vector-only request cannot run before any matrix has been
            // loaded, so it is promoted to a full reload.
            reload_q <= cmd_reload | ~matrix_loaded;
            state    <= S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          // Start only once the whole frame is buffered, so that no burst can
          // stall part-way through.
          if (count >= words_needed) begin
            if (reload_q) begin
              mvm_start_matrix <= 1'b1;
              state            <= S_MHDR;
            end else begin
              mvm_start_vector <= 1'b1;
              state            <= S_VHDR;
            end
          end
        end

        S_MHDR: begin
          idx      <= '0;
          mvm_data <= head;
          state    <= S_MLOAD;
        end

        S_MLOAD: begin
          if (idx == MAT_LAST) begin
            matrix_loaded    <= 1'b1;
            mvm_start_vector <= 1'b1;
            state            <= S_VHDR;
          end else begin
            idx      <= idx + 1'b1;
            mvm_data <= head;
          end
        end

        S_VHDR: begin
          idx      <= '0;
          mvm_data <= head;
          state    <= S_VLOAD;
        end

        S_VLOAD: begin
          if (idx == VEC_LAST) begin
            mvm_start <= 1'b1;
            state     <= S_GO;
          end else begin
            idx      <= idx + 1'b1;
            mvm_data <= head;
          end
        end

        S_GO: state <= S_WAIT_DONE;

        S_WAIT_DONE: begin
          if (mvm_done) begin
            frame_count <= frame_count + 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
